// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide back end for the MUL and DIV instructions.
// One result bit per clock: shift-add multiply, restoring divide.
module muldiv_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] aux,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic               op_r;
  logic [WIDTH-1:0]   opa, opb, opa_nxt, opb_nxt, mcand;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     msum, dshift, ddiff;
  logic               accept, dz, go, last;

  assign accept = start && (state != RUN);
  assign dz     = accept && op && (b == '0);
  assign go     = accept && !dz;
  assign last   = (cnt == CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (go)      state_nxt = RUN;
        else if (dz) state_nxt = DONE;
        else         state_nxt = IDLE;
      end
      RUN:     state_nxt = last ? DONE : RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // MUL: acc = {partial product, multiplier bits shifted out}; opb supplies the next multiplier bit.
  // DIV: acc = {remainder, quotient}; opa shifts the dividend in MSB first.
  always_comb begin
    mcand   = opb[0] ? opa : '0;
    msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    dshift  = {acc[2*WIDTH-1:WIDTH], opa[WIDTH-1]};
    ddiff   = dshift - {1'b0, opb};
    acc_nxt = acc;
    opa_nxt = opa;
    opb_nxt = opb;
    if (!op_r) begin
      acc_nxt = {msum, acc[WIDTH-1:1]};
      opb_nxt = opb >> 1;
    end else begin
      opa_nxt = opa << 1;
      // The remainder stays below the divisor, so ddiff[WIDTH] is a clean borrow flag.
      if (!ddiff[WIDTH]) acc_nxt = {ddiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else               acc_nxt = {dshift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r   <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      aux    <= '0;
      dbz    <= 1'b0;
    end else if (go) begin
      op_r <= op;
      opa  <= a;
      opb  <= b;
      acc  <= '0;
      cnt  <= CW'(WIDTH);
      dbz  <= 1'b0;
    end else if (dz) begin
      result <= '1;
      aux    <= a;
      dbz    <= 1'b1;
    end else if (state == RUN) begin
      acc <= acc_nxt;
      opa <= opa_nxt;
      opb <= opb_nxt;
      cnt <= cnt - 1'b1;
      if (last) begin
        result <= acc_nxt[WIDTH-1:0];
        aux    <= acc_nxt[2*WIDTH-1:WIDTH];
      end
    end
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 16-bit unsigned multiply/divide unit that serves as the execute-stage back end for the `MUL` (opcode `010`) and `DIV` (opcode `011`) instructions of `cpu`. The decode stage latches the two source register values and issues a one-cycle `start`. The unit runs a shift-add or restoring-divide loop, one bit per clock. It then returns a registered result with a one-cycle `done` pulse, which the CPU uses to hold `ready` low until writeback.

## Interface
- `WIDTH`, 16, operand and result width in bits.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  one-cycle request. Accepted only in IDLE or DONE; ignored otherwise.
- `op`  in  1  operation select: 0 = MUL, 1 = DIV. Sampled with `start`.
- `a`  in  WIDTH  multiplicand or dividend (rs1). Sampled with `start`.
- `b`  in  WIDTH  multiplier or divisor (rs2). Sampled with `start`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; `result`/`aux`/`dbz` are valid from this cycle on.
- `result`  out  WIDTH  MUL: product bits [WIDTH-1:0]. DIV: quotient.
- `aux`  out  WIDTH  MUL: product bits [2*WIDTH-1:WIDTH]. DIV: remainder.
- `dbz`  out  1  DIV with `b` == 0. Cleared on the next accepted start.

## Operation
- Reset values:
  - State = IDLE.
  - `busy`=0, `done`=0, `result`=0, `aux`=0, `dbz`=0.
  - Internal counter, accumulator and operand registers = 0.
- States: IDLE, RUN, DONE.
- IDLE, when `start`=1 and DIV with `b`!=0, or any MUL:
  - Latch `op`, `a`, `b`.
  - Load counter = WIDTH and clear the 2*WIDTH accumulator.
  - Clear `dbz`.
  - Go to RUN.
- IDLE, when `start`=1 and DIV with `b`==0:
  - Do not enter RUN.
  - At that edge set `result`=all ones, `aux`=`a`, `dbz`=1.
  - Go to DONE.
- RUN, MUL: each cycle, if multiplier LSB=1, add the multiplicand into the upper half of the accumulator. Then shift {carry, accumulator} right by 1.
- RUN, DIV (restoring): each cycle, shift {remainder, dividend} left by 1. Trial-subtract the divisor from the remainder. If the result is non-negative, keep it and set quotient bit = 1; else quotient bit = 0.
- RUN, counter: decrements each cycle. On the iteration where counter==1, write `result`/`aux` from the final datapath values and go to DONE.
- DONE:
  - `done`=1 for exactly this cycle.
  - Next state: IDLE, or RUN if a new `start` is accepted (back-to-back issue).
- `start` while in RUN: ignored. The operation in flight is unaffected and no error is flagged.
- `result`, `aux` and `dbz` hold their values until the next accepted `start` (or the dbz edge) overwrites them. They never change during RUN.
- All arithmetic is unsigned. The product is exact over 2*WIDTH bits, so no overflow flag is needed.
- `reset` asserted at any time aborts the operation and returns to reset values. No `done` is produced for the aborted operation.

## Timing
- `start` is sampled at edge k:
  - `busy`=1 from edge k to edge k+WIDTH.
  - Iterations occur at edges k+1 … k+WIDTH.
  - `done`=1 from edge k+WIDTH to edge k+WIDTH+1.
  - Latency is WIDTH cycles (16 for the default), i.e. 17 cycles start-to-start when issuing back-to-back.
- Divide by zero: `done`=1 from edge k+1, so latency is 1 cycle. `busy` never rises.
- `done` and `busy` are never high in the same cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- MUL 10×3, start at edge k -> `done` at edge k+16; `result`=30, `aux`=0, `dbz`=0; `busy` high for exactly 16 cycles.
- DIV 10÷3 -> `result`=3, `aux`=1 at edge k+16. Then issue DIV 30÷10 during the DONE cycle -> accepted; `result`=3, `aux`=0 after 16 more cycles.
- MUL 0xFFFF×0xFFFF -> `result`=0x0001, `aux`=0xFFFE.
- DIV 55÷0 -> `done` at edge k+1; `result`=0xFFFF, `aux`=55, `dbz`=1, no `busy`. The next valid MUL clears `dbz`.
- MUL 7×6 started, with `start` pulsed again (DIV 9÷2) at edge k+5 -> ignored; result=42 at edge k+16, and only one `done` pulse.
- DIV 99÷4 started, `reset` asserted at edge k+8 mid-cycle -> all outputs 0 immediately. No `done` is produced. After release, DIV 99÷4 completes with `result`=24, `aux`=3.
